// File: rtl/pipe_reg.sv
// Elastic DEPTH-stage valid/ready register pipeline with bubble collapsing; optional count port under PIPE_REG_COUNT_EN.
// Latency DEPTH cycles; full throughput; in_ready falls only when every stage is held by downstream backpressure, or during flush/reset.
module pipe_reg #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    input  logic             flush
`ifdef PIPE_REG_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] vld_nxt;
    logic [WIDTH-1:0] dat [DEPTH];
    logic             in_fire;

    // A stage may advance if any stage downstream of it is empty or the consumer is taking q.
    always_comb begin
        logic a;
        a = out_ready;
        adv = '0;
        adv[DEPTH-1] = a;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            a = a | !vld[i+1];
            adv[i] = a;
        end
    end

    assign in_ready = (!vld[0] | adv[0]) & !flush & !reset;
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        load = '0;
        load[0] = in_fire;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = vld[i-1] & adv[i-1];
        end
        vld_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld_nxt[i] = load[i] | (vld[i] & !adv[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= '0;
            end
        end else if (flush) begin
            vld <= '0;
        end else begin
            vld <= vld_nxt;
            if (load[0]) begin
                dat[0] <= d;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (load[i]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign q         = dat[DEPTH-1];
    assign out_valid = vld[DEPTH-1];

`ifdef PIPE_REG_COUNT_EN
    localparam int CW = $clog2(DEPTH + 1);
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + CW'(vld_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= '0;
        end else begin
            count <= cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Directed bench for pipe_reg at WIDTH=64, DEPTH=3; count checks compile in with PIPE_REG_COUNT_EN.
module tb_pipe_reg;

    localparam int WIDTH = 64;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic             flush;
`ifdef PIPE_REG_COUNT_EN
    logic [$clog2(DEPTH+1)-1:0] count;
`endif

    int checks = 0;
    int errors = 0;

    pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .flush     (flush)
`ifdef PIPE_REG_COUNT_EN
        ,
        .count     (count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int exp);
`ifdef PIPE_REG_COUNT_EN
        check(tag, 64'(count), 64'(exp));
`endif
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] w30 [5];
    logic [63:0] w31 [4];

    initial begin
        w30[0] = 64'h1;  w30[1] = 64'hA2; w30[2] = 64'hBA; w30[3] = 64'h10; w30[4] = 64'h51;
        w31[0] = 64'h1010; w31[1] = 64'hCC; w31[2] = 64'h55; w31[3] = 64'h123;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; d = 64'hA2; out_ready = 1'b0;

        // Reset held five cycles while a word is offered.
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            @(negedge clk);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_q", q, 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd0);
            chk_cnt("rst_count", 0);
        end
        next_cycle();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 64'(in_ready), 64'd1);
        check("rel_out_valid", 64'(out_valid), 64'd0);

        // Streaming with no backpressure: latency 3, no bubbles.
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            next_cycle();
            in_valid = (k < 5);
            d = (k < 5) ? w30[k] : 64'hDEAD;
            @(negedge clk);
            if (k < 5) check("str_in_ready", 64'(in_ready), 64'd1);
            if (k >= 3 && k < 8) begin
                check("str_out_valid", 64'(out_valid), 64'd1);
                check("str_q", q, w30[k-3]);
            end else begin
                check("str_out_idle", 64'(out_valid), 64'd0);
            end
        end

        // Backpressure: fill three, fourth waits until the head leaves.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            in_valid = 1'b1; d = w31[k];
            @(negedge clk);
            check("bp_accept", 64'(in_ready), 64'd1);
        end
        next_cycle();
        d = w31[3];
        @(negedge clk);
        check("bp_full_in_ready", 64'(in_ready), 64'd0);
        chk_cnt("bp_full_count", 3);
        check("bp_full_q", q, w31[0]);
        next_cycle();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_same_cycle_in_ready", 64'(in_ready), 64'd1);
        check("bp_same_cycle_q", q, w31[0]);
        for (int k = 1; k < 4; k++) begin
            next_cycle();
            in_valid = 1'b0;
            @(negedge clk);
            check("bp_order_valid", 64'(out_valid), 64'd1);
            check("bp_order_q", q, w31[k]);
        end
        next_cycle();
        @(negedge clk);
        check("bp_drained", 64'(out_valid), 64'd0);
        chk_cnt("bp_drained_count", 0);

        // Bubble collapse: A2 settles in the last stage, CC behind it.
        out_ready = 1'b0;
        next_cycle(); in_valid = 1'b1; d = 64'hA2;
        next_cycle(); in_valid = 1'b0;
        next_cycle();
        next_cycle(); in_valid = 1'b1; d = 64'hCC;
        next_cycle(); in_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check("bub_out_valid", 64'(out_valid), 64'd1);
        check("bub_q", q, 64'hA2);
        check("bub_in_ready", 64'(in_ready), 64'd1);
        chk_cnt("bub_count", 2);
        in_valid = 1'b1; d = 64'h77;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk_cnt("pre_flush_count", 3);
        check("pre_flush_in_ready", 64'(in_ready), 64'd0);

        // Flush with a word offered and the head transferring.
        next_cycle();
        flush = 1'b1; in_valid = 1'b1; d = 64'h55; out_ready = 1'b1;
        @(negedge clk);
        check("fl_in_ready", 64'(in_ready), 64'd0);
        check("fl_head_valid", 64'(out_valid), 64'd1);
        check("fl_head_q", q, 64'hA2);
        next_cycle();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_q_kept", q, 64'hA2);
        chk_cnt("fl_count", 0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            check("fl_no_55", 64'(out_valid), 64'd0);
        end

        // Reset and flush together on a full pipeline.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            in_valid = 1'b1; d = 64'(8'h11 * (k + 1));
        end
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk_cnt("rf_full_count", 3);
        check("rf_full_q", q, 64'h11);
        next_cycle();
        reset = 1'b1; flush = 1'b1;
        next_cycle();
        reset = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("rf_out_valid", 64'(out_valid), 64'd0);
        check("rf_q", q, 64'd0);
        check("rf_in_ready", 64'(in_ready), 64'd1);
        chk_cnt("rf_count", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
